// File: rtl/sub_pkg.sv
// Shared definitions for the serial ripple subtractor.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: computes a - b - bin.
// Ports:
//   a, b  - operand bits (minuend, subtrahend)
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial two's-complement subtractor: diff = x - y - b_in, LSB first,
// one bit per clock, with a start/done handshake.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   start       - request, accepted only when busy=0 (IDLE or DONE)
//   x, y, b_in  - operands, latched with an accepted start
//   busy        - high while bits are being processed
//   done        - one-cycle pulse in the cycle after the result registers load
//   diff        - registered difference, held until the next completion
//   b_out       - borrow out of the MSB (unsigned x < y + b_in)
//   overflow    - signed overflow: borrow into MSB XOR borrow out
module serial_ripple_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xa, ya, sh;
  logic [WIDTH-1:0] shifted;
  logic             br;
  logic             msb_bin;
  logic             bit_a, bit_b, bit_d, bit_bout;

  // Single bit-slice reused on every RUN cycle.
  full_subtractor_bit u_fs (
    .a    (bit_a),
    .b    (bit_b),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign bit_a   = xa[cnt];
  assign bit_b   = ya[cnt];
  assign shifted = {bit_d, sh[WIDTH-1:1]};
  // Borrow entering the MSB slice is simply the borrow register while the
  // last bit is being processed.
  assign msb_bin = br;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xa       <= '0;
      ya       <= '0;
      sh       <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      b_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      xa  <= x;
      ya  <= y;
      br  <= b_in;
      cnt <= '0;
      sh  <= '0;
    end else if (state == RUN) begin
      sh <= shifted;
      br <= bit_bout;
      if (cnt == LAST) begin
        diff     <= shifted;
        b_out    <= bit_bout;
        overflow <= msb_bin ^ bit_bout;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] x = '0;
  logic [5:0] y = '0;
  logic       b_in = 1'b0;
  logic       busy, done, b_out, overflow;
  logic [5:0] diff;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb[$];

  serial_ripple_subtractor #(.WIDTH(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .y        (y),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .b_out    (b_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares each completed result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", int'(diff), int'(e.d));
        chk("b_out", int'(b_out), int'(e.bo));
        chk("overflow", int'(overflow), int'(e.ov));
      end
    end
  end

  // Drive a start for one cycle (sampled on the following posedge).
  task automatic issue(input logic [5:0] xv, input logic [5:0] yv, input logic bv,
                       input logic [5:0] ed, input logic ebo, input logic eov);
    exp_t e;
    x = xv; y = yv; b_in = bv; start = 1'b1;
    e.d = ed; e.bo = ebo; e.ov = eov;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the negedge after acceptance, count cycles until done.
  // Optionally pulses an ignored start at cycle pulse_at, and checks diff
  // holds its previous value throughout RUN.
  task automatic wait_done(input int pulse_at, input logic [5:0] hold,
                           output int k, output int bn);
    k = 0;
    bn = 0;
    while (!done && k < 40) begin
      if (busy) begin
        bn++;
        chk("diff_hold", int'(diff), int'(hold));
      end
      if (k == pulse_at) begin
        x = 6'd63; y = 6'd0; b_in = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    int k, bn;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bn;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_b_out", int'(b_out), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 20 - 7 = 13
    issue(6'd20, 6'd7, 1'b0, 6'd13, 1'b0, 1'b0);
    wait_done(-1, 6'd0, k, bn);
    chk("latency_cycles", k, 6);
    chk("busy_cycles", bn, 6);
    chk("done_busy_low", int'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);

    // 5 - 9 = -4
    issue(6'd5, 6'd9, 1'b0, 6'h3C, 1'b1, 1'b0);
    wait_done(-1, 6'd13, k, bn);
    @(negedge clk);

    // 0 - (-32) overflows
    issue(6'd0, 6'h20, 1'b0, 6'h20, 1'b1, 1'b1);
    wait_done(-1, 6'h3C, k, bn);
    @(negedge clk);

    // -32 - 1 overflows
    issue(6'h20, 6'd1, 1'b0, 6'h1F, 1'b0, 1'b1);
    wait_done(-1, 6'h20, k, bn);
    @(negedge clk);

    // 10 - 3 - 1 = 6, then back-to-back 1 - 1 = 0 issued in the DONE cycle
    issue(6'd10, 6'd3, 1'b1, 6'd6, 1'b0, 1'b0);
    wait_done(-1, 6'h1F, k, bn);
    issue(6'd1, 6'd1, 1'b0, 6'd0, 1'b0, 1'b0);
    wait_done(-1, 6'd6, k, bn);
    chk("b2b_gap", k + 1, 7);
    @(negedge clk);

    // 33 - 12: start pulsed with 63/0 on the 3rd RUN cycle must be ignored
    issue(6'd33, 6'd12, 1'b0, 6'd21, 1'b0, 1'b1);
    wait_done(2, 6'd0, k, bn);
    chk("ignored_start_latency", k, 6);
    @(negedge clk);
    @(negedge clk);
    chk("ignored_start_no_rerun", int'(busy), 0);

    // Reset asynchronously in the middle of the 4th RUN cycle
    x = 6'd20; y = 6'd7; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_diff", int'(diff), 21);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_diff", int'(diff), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    bn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) bn++;
    end
    chk("no_done_after_abort", bn, 0);

    // Normal operation resumes
    issue(6'd5, 6'd9, 1'b0, 6'h3C, 1'b1, 1'b0);
    wait_done(-1, 6'd0, k, bn);
    chk("post_reset_latency", k, 6);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
